// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared constants and types for the MFCC front end
package mfcc_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int FRAME_LEN = 256;
    localparam int HOP       = 128;
    localparam int FFT_LEN   = 512;
    localparam int BUF_DEPTH = 512;

    // Bits needed to hold values 0..v-1 (at least 1)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } framer_state_e;

endpackage

// File: rtl/framer_ring_ram.sv
// rtl/framer_ring_ram.sv - ring buffer storage, sync write / async read, no reset
module framer_ring_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/audio_framer.sv
// rtl/audio_framer.sv - cuts a PCM stream into overlapping frames with start/last markers
module audio_framer
    import mfcc_pkg::*;
#(
    parameter int W         = SAMPLE_W,
    parameter int FRAME_LEN = mfcc_pkg::FRAME_LEN,
    parameter int HOP       = mfcc_pkg::HOP,
    parameter int BUF_DEPTH = mfcc_pkg::BUF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    output logic [W-1:0] sample_out,
    output logic         sample_out_valid,
    input  logic         sample_out_ready,
    output logic         frame_start,
    output logic         frame_last,
    output logic         overflow
);

    localparam int AW = clog2(BUF_DEPTH);
    localparam int IW = clog2(FRAME_LEN + 1);
    localparam int PW = clog2((BUF_DEPTH - FRAME_LEN) / HOP + 2);

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]   HOP_P   = (AW+1)'(HOP);
    localparam logic [IW-1:0] FLEN_V  = IW'(FRAME_LEN);
    localparam logic [IW-1:0] HOP_V   = IW'(HOP);

    framer_state_e state, state_n;

    logic [AW:0]   wr_ptr, base, occ;
    logic [IW-1:0] hop_cnt, rd_idx, thresh;
    logic [PW-1:0] pending;
    logic          first_done;
    logic          wr_en, frame_inc, load, last_acc;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    // Extra pointer bit distinguishes a full buffer from an empty one
    assign occ       = wr_ptr - base;
    assign wr_en     = sample_valid && (occ != DEPTH_V);
    assign thresh    = first_done ? HOP_V : FLEN_V;
    assign frame_inc = wr_en && ((hop_cnt + 1'b1) == thresh);
    assign load      = (state == ST_STREAM) && (!sample_out_valid || sample_out_ready)
                       && (rd_idx != FLEN_V);
    assign last_acc  = sample_out_valid && sample_out_ready && frame_last;
    assign rd_addr   = base[AW-1:0] + AW'(rd_idx);

    framer_ring_ram #(.W(W), .DEPTH(BUF_DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (sample_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (pending != '0) state_n = ST_STREAM;
            ST_STREAM: if (last_acc)      state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            base       <= '0;
            hop_cnt    <= '0;
            first_done <= 1'b0;
            pending    <= '0;
            rd_idx     <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_n;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (frame_inc) begin
                    hop_cnt    <= '0;
                    first_done <= 1'b1;
                end else begin
                    hop_cnt <= hop_cnt + 1'b1;
                end
            end
            if (sample_valid && !wr_en) overflow <= 1'b1;
            if (last_acc) base <= base + HOP_P;
            case ({frame_inc, last_acc})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
            if (state == ST_IDLE) rd_idx <= '0;
            else if (load)        rd_idx <= rd_idx + 1'b1;
        end
    end

    // Output register holds steady while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            frame_start      <= 1'b0;
            frame_last       <= 1'b0;
        end else if (load) begin
            sample_out       <= rd_data;
            sample_out_valid <= 1'b1;
            frame_start      <= (rd_idx == '0);
            frame_last       <= (rd_idx == FLEN_V - 1'b1);
        end else if (sample_out_valid && sample_out_ready) begin
            sample_out_valid <= 1'b0;
        end
    end

endmodule
